// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-channel valid/ready selector with round-robin or
// fixed-priority grant and a single registered, back-pressurable output stage.
module rr_mux_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 rr_en,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    logic             load;
    logic             gnt_found;
    logic [SW-1:0]    gnt_idx;
    logic [WIDTH-1:0] chan [N];

    // Unpack the flat input bus so the winner can be picked by index.
    for (genvar i = 0; i < N; i++) begin : g_chan
        assign chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Output stage can take a word when empty or being drained this cycle.
    assign load = !valid_q || out_ready;

    // Grant search: start at ptr (round-robin) or 0 (fixed), wrapping at N-1.
    // Only valid bits and arbitration state feed this, never the data.
    always_comb begin
        int start;
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        start     = rr_en ? int'(ptr_q) : 0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = start + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_found && in_valid[SW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = SW'(idx);
            end
        end
    end

    // Ready goes only to the granted channel, and only when the register can load.
    always_comb begin
        in_ready = '0;
        if (load && gnt_found) in_ready[gnt_idx] = 1'b1;
    end

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (gnt_found) begin
                data_d  = chan[gnt_idx];
                sel_d   = gnt_idx;
                valid_d = 1'b1;
                if (rr_en) ptr_d = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
            end else begin
                // Drained with nothing to replace it: data/sel keep last word.
                valid_d = 1'b0;
            end
        end
    end

    // State registers; reset clears the output stage and pointer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, WIDTH=8) with an output scoreboard.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SW    = 2;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SW-1:0]    s;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic                 rr_en;
    logic [WIDTH-1:0]     out_data;
    logic [SW-1:0]        out_sel;
    logic                 out_valid;
    logic                 out_ready;

    int   n_checks;
    int   n_errors;
    exp_t sb [$];

    rr_mux_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rr_en     (rr_en),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs and let the combinational ready settle.
    task automatic drive(input logic [N-1:0] v, input logic rr, input logic ordy);
        in_valid  = v;
        rr_en     = rr;
        out_ready = ordy;
        #1;
    endtask

    // Advance one edge. If a transfer is expected, push its word to the
    // scoreboard first and compare it against the registered output after.
    task automatic tick(input bit xfer, input logic [WIDTH-1:0] d, input logic [SW-1:0] s);
        exp_t e;
        if (xfer) begin
            e.d = d;
            e.s = s;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (xfer) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_valid", 32'(out_valid), 32'd1);
                check("out_data", 32'(out_data), 32'(e.d));
                check("out_sel", 32'(out_sel), 32'(e.s));
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_valid  = '0;
        rr_en     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // Round-robin, all valid: 0,1,2,3,0 starting from ptr=0
        drive(4'b1111, 1'b1, 1'b1);
        check("rr_rdy0", 32'(in_ready), 32'b0001);
        tick(1, 8'hA0, 2'd0);
        check("rr_rdy1", 32'(in_ready), 32'b0010);
        tick(1, 8'hB1, 2'd1);
        check("rr_rdy2", 32'(in_ready), 32'b0100);
        tick(1, 8'hC2, 2'd2);
        check("rr_rdy3", 32'(in_ready), 32'b1000);
        tick(1, 8'hD3, 2'd3);
        check("rr_rdy0b", 32'(in_ready), 32'b0001);
        tick(1, 8'hA0, 2'd0);
        // ptr now 1

        // Fixed priority: ch1 always beats ch3
        drive(4'b1010, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("fp_rdy", 32'(in_ready), 32'b0010);
            tick(1, 8'hB1, 2'd1);
        end

        // Back to round-robin: ptr was held at 1 through fixed mode
        drive(4'b1010, 1'b1, 1'b1);
        check("rr_resume_rdy", 32'(in_ready), 32'b0010);
        tick(1, 8'hB1, 2'd1);
        check("rr_next_rdy", 32'(in_ready), 32'b1000);
        tick(1, 8'hD3, 2'd3);
        // ptr now 0

        // Load C2 (grant ch2 -> ptr=3), then back-pressure for 3 cycles
        drive(4'b0100, 1'b1, 1'b1);
        check("bp_load_rdy", 32'(in_ready), 32'b0100);
        tick(1, 8'hC2, 2'd2);
        drive(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_rdy", 32'(in_ready), 32'b0000);
            tick(0, 8'h00, 2'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'hC2);
            check("bp_sel", 32'(out_sel), 32'd2);
        end

        // Release with only ch0 valid: wraps 3->0, drain+fill with no bubble
        drive(4'b0001, 1'b1, 1'b1);
        check("wrap_rdy", 32'(in_ready), 32'b0001);
        tick(1, 8'hA0, 2'd0);
        // ptr must now be 1: ch1 wins over ch0
        drive(4'b0011, 1'b1, 1'b1);
        check("wrap_ptr_rdy", 32'(in_ready), 32'b0010);
        tick(1, 8'hB1, 2'd1);

        // Idle drain: valid drops, data/sel hold
        drive(4'b0000, 1'b1, 1'b1);
        check("idle_rdy", 32'(in_ready), 32'b0000);
        tick(0, 8'h00, 2'd0);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_data", 32'(out_data), 32'hB1);
        check("idle_sel", 32'(out_sel), 32'd1);

        // Async reset mid-cycle with a word held under back-pressure
        drive(4'b1000, 1'b1, 1'b1);
        check("pre_rst_rdy", 32'(in_ready), 32'b1000);
        tick(1, 8'hD3, 2'd3);
        drive(4'b0000, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'h00);
        check("arst_sel", 32'(out_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1111, 1'b1, 1'b1);
        check("post_rst_ptr_rdy", 32'(in_ready), 32'b0001);
        tick(1, 8'hA0, 2'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Parametrised N-channel, WIDTH-bit registered multiplexer that generalises the team's 2:1 combinational mux into an arbitrated, flow-controlled selector. Each input channel presents data with a valid/ready handshake. The block grants one channel per cycle, in either round-robin or fixed-priority order, and captures the winner into an output register that supports back-pressure. It sits between multiple producers and a single shared consumer, for example a shared bus or a result port.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- N, 4, number of input channels (≥2; power of two not required)
- SW, $clog2(N), width of the channel index (derived; not to be overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i has data
- in_ready  out  N  channel i transfer accepted this cycle (one-hot or zero)
- rr_en  in  1  1 = round-robin arbitration; 0 = fixed priority, lowest index wins
- out_data  out  WIDTH  registered selected data
- out_sel  out  SW  index of the channel that produced out_data
- out_valid  out  1  output register holds data
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- One clock domain. Reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready is combinational and therefore 0 while out_valid=0 and no input is valid.
- Load enable: load = !out_valid || out_ready. The register accepts new data when it is empty or is being drained in the same cycle.
- Grant logic (combinational):
  - Round-robin (rr_en=1): search from index ptr upward, wrapping N-1→0. The first i with in_valid[i]=1 wins.
  - Fixed priority (rr_en=0): the lowest i with in_valid[i]=1 wins.
- in_ready[g] = load && in_valid[g] for the granted g. All other in_ready bits are 0.
- A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer from channel g at a clock edge:
  - out_data ← in_data[g]
  - out_sel ← g
  - out_valid ← 1
  - In round-robin mode: ptr ← (g==N-1) ? 0 : g+1
- In fixed-priority mode ptr is held. Switching rr_en takes effect in the same cycle; ptr is not reset.
- If load=1 and no in_valid is set: out_valid ← 0 at the edge (when draining); out_data and out_sel hold their last values.
- If load=0 (out_valid=1, out_ready=0): out_data, out_sel, out_valid and ptr all hold. in_ready=0.
- Simultaneous drain and fill (out_valid=1, out_ready=1, some in_valid set): the new word is loaded with no bubble. Throughput is 1 word/cycle.
- Asserting rst mid-transfer clears out_valid immediately, without waiting for a clock edge. Any in-flight word is dropped. ptr returns to 0.

## Timing
- Latency: 1 cycle. A word accepted at edge k appears on out_data with out_valid=1 immediately after edge k.
- in_ready is a combinational function of in_valid, rr_en, ptr, out_valid and out_ready. It has no combinational dependence on in_data.
- out_data, out_sel and out_valid are driven directly from flops. There is no combinational path from any input to these outputs.
- Stability: while out_valid=1 && out_ready=0, out_data and out_sel do not change.
- Fairness: under round-robin, if channel i stays valid it is granted within N transfers.

## Test plan
- Reset: assert rst=1 asynchronously mid-cycle with out_valid=1 → out_valid=0, out_data=0x00, out_sel=0 before the next clock edge. After release, ptr=0.
- Round-robin, all valid (N=4, WIDTH=8; in_data ch0..3 = 0xA0,0xB1,0xC2,0xD3; rr_en=1; out_ready=1) → over 5 consecutive cycles out_sel = 0,1,2,3,0 and out_data = 0xA0,0xB1,0xC2,0xD3,0xA0. in_ready is one-hot each cycle.
- Fixed priority: rr_en=0, in_valid=4'b1010 → out_sel=1, out_data=0xB1 every cycle. in_ready=4'b0010. Channel 3 is never granted.
- Back-pressure: out_ready=0 for 3 cycles after out_valid=1 with out_data=0xC2 → out_data stays 0xC2, in_ready=4'b0000, ptr unchanged. Raising out_ready=1 gives a drain and a new load in the same edge, with no empty cycle.
- Wrap and sparse valid: ptr=3 after a grant to ch2, in_valid=4'b0001 → ch0 is granted (wrap 3→0), out_sel=0, and ptr becomes 1.
- Idle drain: a single word with out_ready=1 and no further in_valid → out_valid drops to 0 on the next edge. out_data holds its last value.
